// File: rtl/adc_capture_core_if.sv
// adc_capture_core_if
// AXI4-Stream sample bus from the RFDC ADC tile into the capture engine.
//   tdata  : one ADC beat (AXIS_DATA_WIDTH bits)
//   tvalid : beat valid
//   tready : sink ready; the capture engine never back-pressures
// Modports: master drives tdata/tvalid, slave drives tready.
interface adc_capture_core_if #(
    parameter int AXIS_DATA_WIDTH = 256
) ();
    logic [AXIS_DATA_WIDTH-1:0] tdata;
    logic                       tvalid;
    logic                       tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/adc_capture_core.sv
// adc_capture_core
// Timestamp-triggered capture of the ADC AXI4-Stream into a local FIFO.
// A single-cycle arm strobe loads a start time and a beat count. Once the
// shared 64-bit timeline counter reaches the start time, the next cmd_length
// valid beats are consumed and written into the buffer (dropped if it is
// full). Host logic drains the buffer through a registered read port.
// Ports:
//   s_axi_aclk, s_axi_aresetn  : clock, asynchronous active-low reset
//   s00_axis (slave)           : ADC sample stream, tready always high
//   counter                    : timeline counter from TimeController
//   arm, cmd_timestamp,
//   cmd_length                 : capture command
//   flush, err_clear           : abort/empty, clear sticky errors
//   buf_rd_en, buf_dout,
//   buf_empty, buf_full,
//   buf_count                  : buffer read side and fill status
//   armed, busy, capture_done  : engine status
//   overflow_error,
//   timestamp_error            : sticky error flags
module adc_capture_core #(
    parameter int AXIS_DATA_WIDTH = 256,
    parameter int FIFO_ADDR_WIDTH = 6,
    parameter int LEN_WIDTH       = 16
) (
    input  logic                       s_axi_aclk,
    input  logic                       s_axi_aresetn,
    adc_capture_core_if.slave          s00_axis,
    input  logic [63:0]                counter,
    input  logic                       arm,
    input  logic [63:0]                cmd_timestamp,
    input  logic [LEN_WIDTH-1:0]       cmd_length,
    input  logic                       flush,
    input  logic                       err_clear,
    input  logic                       buf_rd_en,
    output logic [AXIS_DATA_WIDTH-1:0] buf_dout,
    output logic                       buf_empty,
    output logic                       buf_full,
    output logic [FIFO_ADDR_WIDTH:0]   buf_count,
    output logic                       armed,
    output logic                       busy,
    output logic                       capture_done,
    output logic                       overflow_error,
    output logic                       timestamp_error
);

    localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;

    localparam logic [FIFO_ADDR_WIDTH:0] FULL_COUNT = {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};
    localparam logic [LEN_WIDTH-1:0]     LEN_ONE    = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [FIFO_ADDR_WIDTH:0] CNT_ONE    = {{FIFO_ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE  = {{(FIFO_ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]                 state;
    logic [63:0]                ts_reg;
    logic [LEN_WIDTH-1:0]       remain;
    logic                       tready_q;
    logic                       done_p1;
    logic                       ovf_q;
    logic                       tserr_q;

    logic [AXIS_DATA_WIDTH-1:0] mem [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
    logic [FIFO_ADDR_WIDTH:0]   count;
    logic [AXIS_DATA_WIDTH-1:0] dout_p1;

    logic full;
    logic empty;
    logic beat;
    logic last_beat;
    logic wr_en;
    logic rd_en;
    logic ovf_set;
    logic trigger;
    logic late;

    // Flush suppresses every data movement on its edge, so all enables are
    // gated with it here rather than in each register block.
    always_comb begin
        full      = (count == FULL_COUNT);
        empty     = (count == '0);
        beat      = (state == CAPTURE) && s00_axis.tvalid && !flush;
        last_beat = beat && (remain == LEN_ONE);
        wr_en     = beat && !full;
        ovf_set   = beat && full;
        rd_en     = buf_rd_en && !empty && !flush;
        trigger   = (state == ARMED) && (counter >= ts_reg) && !flush;
        late      = trigger && (counter > ts_reg);
    end

    // Control: state, remaining beats, completion pulse
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state    <= IDLE;
            remain   <= '0;
            done_p1  <= 1'b0;
            tready_q <= 1'b0;
        end else begin
            tready_q <= 1'b1;
            done_p1  <= last_beat;
            if (flush) begin
                state  <= IDLE;
                remain <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm && (cmd_length != '0)) begin
                            state  <= ARMED;
                            remain <= cmd_length;
                        end
                    end
                    ARMED: begin
                        if (trigger) state <= CAPTURE;
                    end
                    CAPTURE: begin
                        if (beat) begin
                            remain <= remain - LEN_ONE;
                            if (remain == LEN_ONE) state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Start time is command data; only the state decides whether it matters.
    always_ff @(posedge s_axi_aclk) begin
        if ((state == IDLE) && arm && (cmd_length != '0) && !flush) ts_reg <= cmd_timestamp;
    end

    // Sticky errors: a set in the same cycle as err_clear takes precedence.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            ovf_q   <= 1'b0;
            tserr_q <= 1'b0;
        end else begin
            if (ovf_set)        ovf_q <= 1'b1;
            else if (err_clear) ovf_q <= 1'b0;
            if (late)           tserr_q <= 1'b1;
            else if (err_clear) tserr_q <= 1'b0;
        end
    end

    // Buffer pointers, occupancy and registered read word
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            dout_p1 <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                dout_p1 <= mem[rd_ptr];
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (wr_en) mem[wr_ptr] <= s00_axis.tdata;
    end

    // tready is forced low combinationally while reset is held.
    assign s00_axis.tready = tready_q & s_axi_aresetn;

    assign buf_dout        = dout_p1;
    assign buf_empty       = empty;
    assign buf_full        = full;
    assign buf_count       = count;
    assign armed           = (state == ARMED);
    assign busy            = (state != IDLE);
    assign capture_done    = done_p1;
    assign overflow_error  = ovf_q;
    assign timestamp_error = tserr_q;

endmodule

// File: tb/tb_adc_capture_core.sv
// tb_adc_capture_core
// Directed bench for adc_capture_core. The stimulus process drives the
// timeline counter (tdata mirrors the counter value, so each beat carries its
// own cycle index), issues commands and checks status flags. Words expected
// out of the buffer are queued by the stimulus; a monitor process compares
// buf_dout against the queue after every pop.
module tb_adc_capture_core;

    localparam int DW = 256;
    localparam int AW = 6;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   counter;
    logic          arm;
    logic [63:0]   cmd_timestamp;
    logic [LW-1:0] cmd_length;
    logic          flush;
    logic          err_clear;
    logic          buf_rd_en;
    logic [DW-1:0] buf_dout;
    logic          buf_empty;
    logic          buf_full;
    logic [AW:0]   buf_count;
    logic          armed;
    logic          busy;
    logic          capture_done;
    logic          overflow_error;
    logic          timestamp_error;

    int n_vec  = 0;
    int n_miss = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    adc_capture_core_if #(.AXIS_DATA_WIDTH(DW)) s00_axis ();

    adc_capture_core #(
        .AXIS_DATA_WIDTH(DW),
        .FIFO_ADDR_WIDTH(AW),
        .LEN_WIDTH      (LW)
    ) dut (
        .s_axi_aclk     (clk),
        .s_axi_aresetn  (rst_n),
        .s00_axis       (s00_axis),
        .counter        (counter),
        .arm            (arm),
        .cmd_timestamp  (cmd_timestamp),
        .cmd_length     (cmd_length),
        .flush          (flush),
        .err_clear      (err_clear),
        .buf_rd_en      (buf_rd_en),
        .buf_dout       (buf_dout),
        .buf_empty      (buf_empty),
        .buf_full       (buf_full),
        .buf_count      (buf_count),
        .armed          (armed),
        .busy           (busy),
        .capture_done   (capture_done),
        .overflow_error (overflow_error),
        .timestamp_error(timestamp_error)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (counter %0d)", name, act, exp, counter);
        end
    endtask

    task automatic set_counter(input logic [63:0] v);
        counter       = v;
        s00_axis.tdata = DW'(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        set_counter(counter + 64'd1);
    endtask

    task automatic push_range(input int first, input int last, input int step);
        for (int v = first; v <= last; v += step) exp_q.push_back(DW'(v));
    endtask

    task automatic do_arm(input logic [63:0] ts, input logic [LW-1:0] len);
        arm           = 1'b1;
        cmd_timestamp = ts;
        cmd_length    = len;
        tick();
        arm = 1'b0;
    endtask

    task automatic drain();
        buf_rd_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (buf_empty) break;
            tick();
        end
        buf_rd_en = 1'b0;
        check("drain_empty", 64'(buf_empty), 64'd1);
        tick();
        tick();
        check("drain_queue_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Monitor: a pop decided at one edge is checked at the following negedge.
    initial begin : monitor
        bit pend;
        forever begin
            @(negedge clk);
            if (pend) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL rd_unexpected: got %0h expected no word", buf_dout);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    n_vec++;
                    if (buf_dout !== e) begin
                        n_miss++;
                        $display("FAIL rd_data: got %0h expected %0h", buf_dout, e);
                    end
                end
            end
            pend = rst_n && buf_rd_en && !buf_empty && !flush;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst_n           = 1'b0;
        arm             = 1'b0;
        cmd_timestamp   = '0;
        cmd_length      = '0;
        flush           = 1'b0;
        err_clear       = 1'b0;
        buf_rd_en       = 1'b0;
        s00_axis.tvalid = 1'b0;
        set_counter(64'd0);

        // Reset state
        tick(); tick(); tick();
        check("rst_tready", 64'(s00_axis.tready), 64'd0);
        check("rst_empty", 64'(buf_empty), 64'd1);
        check("rst_full", 64'(buf_full), 64'd0);
        check("rst_count", 64'(buf_count), 64'd0);
        check("rst_dout", buf_dout[63:0], 64'd0);
        check("rst_armed", 64'(armed), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(capture_done), 64'd0);
        check("rst_ovf", 64'(overflow_error), 64'd0);
        check("rst_tserr", 64'(timestamp_error), 64'd0);
        rst_n = 1'b1;
        check("rel_tready_pre", 64'(s00_axis.tready), 64'd0);
        tick();
        check("rel_tready", 64'(s00_axis.tready), 64'd1);

        // Basic capture: ts=100, len=4, armed at counter 50
        s00_axis.tvalid = 1'b1;
        set_counter(64'd50);
        push_range(101, 104, 1);
        do_arm(64'd100, 16'd4);
        check("t1_armed", 64'(armed), 64'd1);
        check("t1_busy", 64'(busy), 64'd1);
        do_arm(64'd60, 16'd9);              // ignored while armed
        while (counter < 64'd104) tick();
        check("t1_done_early", 64'(capture_done), 64'd0);
        check("t1_busy_last", 64'(busy), 64'd1);
        tick();
        check("t1_done", 64'(capture_done), 64'd1);
        check("t1_idle", 64'(busy), 64'd0);
        check("t1_count", 64'(buf_count), 64'd4);
        check("t1_tserr", 64'(timestamp_error), 64'd0);
        tick();
        check("t1_done_once", 64'(capture_done), 64'd0);
        drain();

        // Late trigger: ts=10 armed at counter 20
        set_counter(64'd20);
        push_range(22, 23, 1);
        do_arm(64'd10, 16'd2);
        check("t2_tserr_pre", 64'(timestamp_error), 64'd0);
        tick();
        check("t2_tserr", 64'(timestamp_error), 64'd1);
        check("t2_capture", 64'(busy && !armed), 64'd1);
        tick(); tick();
        check("t2_done", 64'(capture_done), 64'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("t2_tserr_clr", 64'(timestamp_error), 64'd0);
        drain();

        // Overflow: len=70 with no reads
        set_counter(64'd1000);
        push_range(1003, 1066, 1);
        do_arm(64'd1002, 16'd70);
        while (counter < 64'd1067) tick();
        check("t3_full", 64'(buf_full), 64'd1);
        check("t3_count", 64'(buf_count), 64'd64);
        check("t3_ovf_pre", 64'(overflow_error), 64'd0);
        tick();
        check("t3_ovf", 64'(overflow_error), 64'd1);
        while (counter < 64'd1072) tick();
        check("t3_done_early", 64'(capture_done), 64'd0);
        tick();
        check("t3_done", 64'(capture_done), 64'd1);
        check("t3_count_end", 64'(buf_count), 64'd64);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("t3_ovf_clr", 64'(overflow_error), 64'd0);

        // Full buffer: simultaneous read and write, err_clear racing a set
        set_counter(64'd2000);
        do_arm(64'd2002, 16'd1);
        tick();
        tick();
        buf_rd_en = 1'b1;
        err_clear = 1'b1;
        tick();
        buf_rd_en = 1'b0;
        err_clear = 1'b0;
        check("t6_count", 64'(buf_count), 64'd63);
        check("t6_full", 64'(buf_full), 64'd0);
        check("t6_ovf_setwins", 64'(overflow_error), 64'd1);
        check("t6_done", 64'(capture_done), 64'd1);
        check("t6_dout", buf_dout[63:0], 64'd1003);
        tick();
        check("t6_dout_hold", buf_dout[63:0], 64'd1003);
        drain();

        // Gapped tvalid: len=3, valid on odd counter values only
        set_counter(64'd3000);
        s00_axis.tvalid = 1'b0;
        push_range(3003, 3007, 2);
        do_arm(64'd3002, 16'd3);
        s00_axis.tvalid = counter[0];
        while (counter < 64'd3007) begin
            tick();
            s00_axis.tvalid = counter[0];
            if (counter == 64'd3006) check("t4_done_3006", 64'(capture_done), 64'd0);
        end
        check("t4_busy", 64'(busy), 64'd1);
        tick();
        check("t4_done", 64'(capture_done), 64'd1);
        check("t4_count", 64'(buf_count), 64'd3);
        s00_axis.tvalid = 1'b1;
        drain();

        // Flush after two beats, then arm with length 0
        set_counter(64'd4000);
        do_arm(64'd4002, 16'd5);
        while (counter < 64'd4005) tick();
        check("t5_count_pre", 64'(buf_count), 64'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_idle", 64'(busy), 64'd0);
        check("t5_count", 64'(buf_count), 64'd0);
        check("t5_empty", 64'(buf_empty), 64'd1);
        check("t5_done", 64'(capture_done), 64'd0);
        check("t5_ovf_kept", 64'(overflow_error), 64'd1);
        tick();
        check("t5_done_after", 64'(capture_done), 64'd0);
        do_arm(64'd5, 16'd0);
        check("t5_len0_armed", 64'(armed), 64'd0);
        check("t5_len0_busy", 64'(busy), 64'd0);

        // Pointer wrap: 130 beats streamed through with continuous reads
        set_counter(64'd5000);
        push_range(5003, 5132, 1);
        buf_rd_en = 1'b1;
        do_arm(64'd5002, 16'd130);
        while (counter < 64'd5133) tick();
        check("t7_done", 64'(capture_done), 64'd1);
        check("t7_count", 64'(buf_count), 64'd1);
        drain();

        // Reset mid-capture discards buffer and command
        set_counter(64'd6000);
        do_arm(64'd6002, 16'd5);
        while (counter < 64'd6005) tick();
        check("t8_count_pre", 64'(buf_count), 64'd2);
        rst_n = 1'b0;
        #1;
        check("t8_count", 64'(buf_count), 64'd0);
        check("t8_busy", 64'(busy), 64'd0);
        check("t8_tready", 64'(s00_axis.tready), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t8_empty", 64'(buf_empty), 64'd1);
        check("t8_armed", 64'(armed), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/adc_capture_core.md
# adc_capture_core

Timestamp-triggered capture engine for the RFDC ADC path. It is the receive-side counterpart of the DAC output chain. It accepts the continuous AXI4-Stream sample stream from an RFDC ADC tile. When the shared 64-bit timeline counter reaches a programmed start time, it stores a programmed number of beats into an internal buffer, which host-side readout logic then drains. It runs on the AXI clock alongside the RTO cores and is driven by the same TimeController counter.

## Interface
- AXIS_DATA_WIDTH, 256, width of one ADC stream beat and one buffer word
- FIFO_ADDR_WIDTH, 6, log2 of buffer depth (depth 64 beats)
- LEN_WIDTH, 16, width of capture length field
- s_axi_aclk  in  1  single clock for all logic, including the AXIS input
- s_axi_aresetn  in  1  reset, asynchronous, active-low
- s00_axis_tdata  in  AXIS_DATA_WIDTH  ADC sample beat
- s00_axis_tvalid  in  1  beat valid
- s00_axis_tready  out  1  always-ready indication; the ADC stream is never back-pressured
- counter  in  64  timeline counter from TimeController
- arm  in  1  single-cycle command strobe
- cmd_timestamp  in  64  capture start time, sampled with arm
- cmd_length  in  LEN_WIDTH  number of beats to capture, sampled with arm
- flush  in  1  abort capture and empty buffer
- err_clear  in  1  clear sticky error flags
- buf_rd_en  in  1  buffer read request
- buf_dout  out  AXIS_DATA_WIDTH  read data
- buf_empty  out  1  buffer empty
- buf_full  out  1  buffer full
- buf_count  out  FIFO_ADDR_WIDTH+1  words held
- armed  out  1  state is ARMED
- busy  out  1  state is ARMED or CAPTURE
- capture_done  out  1  one-cycle pulse when capture completes
- overflow_error  out  1  sticky; a beat was dropped because the buffer was full
- timestamp_error  out  1  sticky; the start time was already passed when the capture triggered

## Operation
- States: IDLE, ARMED, CAPTURE.
- IDLE → ARMED on arm with cmd_length ≠ 0. On that edge, cmd_timestamp goes to ts_reg and cmd_length goes to remain.
  - arm with cmd_length = 0 is ignored.
  - arm in ARMED or CAPTURE is ignored; the captured parameters are unchanged.
- ARMED → CAPTURE at the edge where counter ≥ ts_reg (unsigned 64-bit compare).
  - On the same edge, timestamp_error is set if counter > ts_reg.
- CAPTURE: every cycle with s00_axis_tvalid = 1 consumes one beat and decrements remain.
  - If the buffer is not full, the beat is written.
  - If the buffer is full, the beat is dropped, overflow_error is set, and remain still decrements. Capture duration stays tied to the timeline.
  - Cycles with tvalid = 0 do not decrement remain.
- CAPTURE → IDLE on the edge that consumes the beat with remain = 1. capture_done is high for the following single cycle.
- flush has priority over all other inputs. On that edge:
  - state goes to IDLE and remain is cleared;
  - the buffer is emptied (pointers and count reset);
  - no capture_done is issued;
  - the error flags are unaffected.
- err_clear clears both sticky flags. If an error sets in the same cycle as err_clear, the set wins.
- Buffer: synchronous FIFO with a registered read.
  - buf_rd_en with buf_empty = 0 pops the head word; buf_dout shows it the next cycle and holds until the next pop.
  - buf_rd_en while empty is ignored.
  - full and empty are evaluated from the pre-edge state. A write while full is rejected even if a read occurs in the same cycle. A read while empty is ignored even if a write occurs in the same cycle.
  - Simultaneous read and write when neither full nor empty leaves buf_count unchanged.
  - Pointers wrap modulo 2^FIFO_ADDR_WIDTH.

## Timing
- Reset values:
  - state IDLE; s00_axis_tready 0 while reset is asserted, 1 from the first edge after release;
  - buf_empty 1; buf_full 0; buf_count 0; buf_dout 0;
  - armed 0; busy 0; capture_done 0; overflow_error 0; timestamp_error 0.
- Reset is asserted asynchronously and released synchronously to s_axi_aclk. Reset mid-capture discards the buffer contents and the pending command.
- arm at edge k: armed = 1 after edge k.
- Trigger: if counter = T = ts_reg during cycle k, then CAPTURE is entered at edge k. The first beat captured is the one valid in cycle k+1.
- With continuous tvalid and length L:
  - beats from cycles k+1 … k+L are captured;
  - the state returns to IDLE at the edge ending cycle k+L;
  - capture_done is high in cycle k+L+1.
- Write-to-read latency: a word written at edge n gives buf_empty = 0 after edge n. With buf_rd_en asserted in cycle n+1, buf_dout is valid after edge n+1.
- No combinational path from any input to any output other than s00_axis_tready's reset gating.

## Test plan
- Arm with ts = 100 and len = 4 while counter = 50; drive tdata = beat index continuously. The buffer holds the beats present in cycles where counter = 101..104. capture_done pulses once in the cycle counter = 105. timestamp_error stays 0.
- Arm with ts = 10 while counter = 20. CAPTURE starts on the next edge and timestamp_error = 1. Assert err_clear: the flag returns to 0.
- Arm with len = 70 and no reads. 64 beats are stored, buf_full = 1, 6 beats are dropped, and overflow_error = 1. capture_done still pulses after 70 valid beats.
- Toggle tvalid 1/0 during a len = 3 capture. Exactly 3 beats are stored and capture_done is delayed by the idle cycles.
- Assert flush mid-capture after 2 beats. Result: IDLE, buf_count = 0, no capture_done. arm with len = 0 is ignored: armed stays 0.
- With the buffer full, perform simultaneous read and write. The write is rejected, buf_count = 63, and buf_dout shows the oldest word. Fill and drain 130 words to exercise pointer wrap and confirm the output order.
